// File: rtl/lfsr_cnt_sched.sv
// lfsr_cnt_sched: round-robin two-requester scheduler driving a shared LFSR count-to counter (req/seed/term in, gnt/done/err/busy out, data/count_to/load/cen to counter, tercnt from counter)
module lfsr_cnt_sched #(
  parameter int width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [width-1:0] seed0,
  input  logic [width-1:0] seed1,
  input  logic [width-1:0] term0,
  input  logic [width-1:0] term1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic             busy,
  output logic [width-1:0] data,
  output logic [width-1:0] count_to,
  output logic             load,
  output logic             cen,
  input  logic             tercnt
);
  typedef enum logic [1:0] {st_idle, st_load, st_run, st_finish} state_t;
  state_t state, state_n;
  logic sel, rr, err_flag, pick, any_req;
  logic [width-1:0] timer;
  assign any_req = req0 | req1;
  assign pick = (req0 & req1) ? rr : req1;
  always_comb begin
    state_n = state;
    case (state)
      st_idle:   state_n = any_req ? st_load : st_idle;
      st_load:   state_n = st_run;
      st_run:    state_n = (tercnt || (&timer)) ? st_finish : st_run;
      st_finish: state_n = st_idle;
      default:   state_n = st_idle;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= st_idle;
      sel      <= 1'b0;
      rr       <= 1'b0;
      err_flag <= 1'b0;
      timer    <= '0;
      data     <= '0;
      count_to <= '0;
    end else begin
      state <= state_n;
      if (state == st_idle && any_req) begin
        sel      <= pick;
        data     <= pick ? seed1 : seed0;
        count_to <= pick ? term1 : term0;
      end
      if (state == st_load) timer <= '0;
      if (state == st_run) begin
        timer    <= timer + width'(1);
        err_flag <= ~tercnt;
      end
      if (state == st_finish) rr <= ~sel;
    end
  end
  assign busy  = state != st_idle;
  assign load  = state == st_load;
  assign cen   = state == st_run;
  assign gnt0  = busy & ~sel;
  assign gnt1  = busy & sel;
  assign done0 = (state == st_finish) & ~sel;
  assign done1 = (state == st_finish) & sel;
  assign err   = (state == st_finish) & err_flag;
endmodule

// File: tb/tb_lfsr_cnt_sched.sv
// tb_lfsr_cnt_sched: directed self-checking bench for lfsr_cnt_sched
module tb_lfsr_cnt_sched;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [5:0] seed0 = '0, seed1 = '0, term0 = '0, term1 = '0;
  logic gnt0, gnt1, done0, done1, err, busy, load, cen, tercnt;
  logic [5:0] data, count_to, cnt;
  logic attached = 1'b1, tc_stub = 1'b0;
  int checks = 0, errors = 0;
  int ncen, nboth, nerr_at_done, ndone;

  lfsr_cnt_sched #(.width(6)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .seed0(seed0), .seed1(seed1), .term0(term0), .term1(term1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err), .busy(busy),
    .data(data), .count_to(count_to), .load(load), .cen(cen), .tercnt(tercnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) cnt <= load ? data : (cen ? cnt + 6'd1 : cnt);
  assign tercnt = attached ? (cnt == count_to) : tc_stub;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to_done(input int limit);
    ncen = 0; nboth = 0; nerr_at_done = 0; ndone = 0;
    for (int i = 0; i < limit && ndone == 0; i++) begin
      ncen += int'(cen);
      nboth += int'(cen & load);
      if (done0 | done1) begin
        ndone++;
        nerr_at_done = int'(err);
      end
      if (ndone == 0) tick();
    end
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {gnt0, gnt1, done0, done1, err, load, cen}, 0);
    chk("rst_data", data, 0);
    chk("rst_count_to", count_to, 0);
    #10 reset = 1'b0;
    // single request, seed == term
    seed0 = 6'h15; term0 = 6'h15; req0 = 1'b1;
    tick();
    chk("t1_load", {gnt0, gnt1, load, cen, busy}, 5'b10101);
    chk("t1_data", data, 6'h15);
    tick();
    chk("t1_run", {gnt0, load, cen, done0}, 4'b1010);
    tick();
    chk("t1_finish", {gnt0, cen, done0, done1, err}, 5'b10100);
    req0 = 1'b0;
    tick();
    chk("t1_idle", {gnt0, busy, done0}, 0);
    // both requesters from reset release
    reset = 1'b1;
    #1;
    seed0 = 6'h01; term0 = 6'h01; seed1 = 6'h02; term1 = 6'h02;
    req0 = 1'b1; req1 = 1'b1;
    #1 reset = 1'b0;
    tick();
    chk("t2_first_gnt", {gnt0, gnt1}, 2'b10);
    tick();
    tick();
    chk("t2_done0", {done0, done1}, 2'b10);
    tick();
    chk("t2_gap", {busy, gnt0, gnt1}, 0);
    tick();
    chk("t2_second_gnt", {gnt0, gnt1}, 2'b01);
    chk("t2_data1", data, 6'h02);
    tick();
    tick();
    chk("t2_done1", {done0, done1, err}, 3'b010);
    tick();
    tick();
    chk("t2_third_gnt", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    chk("t2_done0_dropped", done0, 1);
    tick();
    // timeout
    attached = 1'b0; tc_stub = 1'b0; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    run_to_done(100);
    chk("t3_cen_cycles", ncen, 64);
    chk("t3_err", nerr_at_done, 1);
    chk("t3_done0", done0, 1);
    chk("t3_no_overlap", nboth, 0);
    tick();
    chk("t3_busy_drop", busy, 0);
    // counter reaches term on the 5th RUN cycle
    attached = 1'b1; seed0 = 6'h00; term0 = 6'h04; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    run_to_done(100);
    chk("t4_cen_cycles", ncen, 5);
    chk("t4_err", nerr_at_done, 0);
    tick();
    // reset mid-RUN
    attached = 1'b0; tc_stub = 1'b0; req0 = 1'b1;
    tick();
    tick();
    tick();
    chk("t5_running", {cen, gnt0, busy}, 3'b111);
    reset = 1'b1;
    #1;
    chk("t5_async_clear", {cen, gnt0, gnt1, busy, done0, done1}, 0);
    req0 = 1'b0; req1 = 1'b1;
    tick();
    chk("t5_no_done", {done0, done1, busy}, 0);
    reset = 1'b0;
    tick();
    chk("t5_gnt1", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    tc_stub = 1'b1;
    tick();
    tick();
    chk("t5_done1", {done1, err}, 2'b10);
    tick();
    // seed change during RUN is ignored
    tc_stub = 1'b0; seed0 = 6'h0A; term0 = 6'h0A; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    seed0 = 6'h33;
    tick();
    chk("t6_data_held", data, 6'h0A);
    tc_stub = 1'b1;
    tick();
    tick();
    tc_stub = 1'b0; req0 = 1'b1;
    tick();
    chk("t6_data_new", data, 6'h33);
    req0 = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_cnt_sched.md
# lfsr_cnt_sched

Two-requester scheduler for one shared LFSR dynamic-count-to counter (parameterised `width`; ports `data`, `count_to`, `load`, `cen`, `tercnt`). Requesters each present a seed and a terminal value. The block arbitrates round-robin, loads the counter, runs it until `tercnt` or a timeout, then reports completion to the winner. It sits between the requesting logic and the counter instance and is the only driver of the counter's control inputs.

## Interface

**Parameters**
- `width`, default 6: counter width; also the width of the internal timeout timer.

**Ports**
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `req0`, `req1`  in  1  request level; held high until the matching `done` pulse.
- `seed0`, `seed1`  in  width  value loaded into the counter for that requester.
- `term0`, `term1`  in  width  count-to value for that requester.
- `gnt0`, `gnt1`  out  1  high from the LOAD cycle through the FINISH cycle of that requester's service.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `doneN` when the service timed out.
- `busy`  out  1  high in any state other than IDLE.
- `data`  out  width  to counter; latched seed.
- `count_to`  out  width  to counter; latched term.
- `load`  out  1  to counter; synchronous active-high load pulse.
- `cen`  out  1  to counter; count enable.
- `tercnt`  in  1  from counter; high while count equals `count_to`.

## Operation
- States: IDLE, LOAD, RUN, FINISH. Moore machine: `gnt`, `load`, `cen`, `done`, `err` and `busy` are decoded from registered state and registers only.
- **IDLE**
  - If exactly one `req` is high, select it.
  - If both are high, select the requester indicated by the round-robin pointer `rr`.
  - On selection: latch `seedN` into `data`, `termN` into `count_to`, and the selected index into `sel`; go to LOAD.
- **LOAD**
  - `load=1`, `cen=0`, `gnt[sel]=1`.
  - Clear the timer; go to RUN.
- **RUN**
  - `cen=1`; timer increments each cycle.
  - If `tercnt=1`, go to FINISH with `err_flag=0`.
  - Otherwise, if the timer equals all-ones (the 2^width-th RUN cycle), go to FINISH with `err_flag=1`.
  - `tercnt` takes priority over timeout in the same cycle.
- **FINISH**
  - `cen=0`, `done[sel]=1`, `err=err_flag`, `gnt[sel]=1`.
  - `rr <= ~sel`; go to IDLE.
- `seedN`/`termN` changes after latching are ignored until the next grant.
- A `req` still high in the IDLE cycle after FINISH counts as a new request. Arbitration uses the updated `rr`, so a continuous competing requester is served next.
- `seed == term`: `tercnt` is already high in the first RUN cycle, so RUN lasts exactly 1 cycle.
- A request dropped during service is ignored; service completes and `done` still pulses.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE; `rr=0`; timer = 0.
  - `data = count_to = 0`.
  - All outputs 0, including `cen` and `load`. No `done` is produced for an aborted service.
- Sequence for a request sampled at edge k: LOAD during cycle k+1, first RUN cycle k+2.
- With R RUN cycles: FINISH in cycle k+2+R, IDLE in cycle k+3+R.
- Minimum service is 4 cycles (R=1). Maximum is 2^width+3 cycles (67 at `width`=6).
- Back-to-back services have a 1-cycle IDLE gap.
- `load` and `cen` are never high in the same cycle.

## Test plan
- Single request, `seed0=term0=6'h15`, `req0` sampled at edge 0, counter instance attached → `gnt0` cycles 1–3, `load` cycle 1, `cen` cycle 2 only, `done0` cycle 3, `err=0`, `data=6'h15`.
- Both requests at reset release, `rr=0` → req0 served first; with both held, req1 is served next (`gnt1` follows 1 IDLE cycle after `done0`), then req0 again.
- `tercnt` stubbed low, `width=6` → `cen` high exactly 64 cycles, then `done0` and `err` pulse together; `busy` drops the next cycle.
- `tercnt` stubbed high on the 5th RUN cycle → exactly 5 `cen` cycles, `done` with `err=0`.
- `reset` asserted mid-RUN → `cen`, `gnt`, `busy` go 0 immediately, no `done`. After release with `req1` high, `rr=0` and req1 is granted.
- `seed0` changed during RUN → `data` unchanged until the next grant.
